// File: rtl/nn_softconvnode_p.sv
// Stochastic-computing convolution node with a cancellation counter, polarity
// register and activation, plus a fixed-length window that counts activation ones.
module nn_softconvnode_p #(
    parameter int N    = 4,
    parameter int CW   = 6,
    parameter int LW   = 10,
    parameter int MODE = 1
) (
    input  logic          CLK,
    input  logic          INIT,
    input  logic [N-1:0]  a,
    input  logic [N-1:0]  alpha,
    input  logic [N-1:0]  SIGN_alpha,
    input  logic          beta,
    input  logic          SIGN_beta,
    input  logic          start,
    output logic          z,
    output logic          SIGN_z,
    output logic          zp,
    output logic          a_out,
    output logic          SIGN_a_out,
    output logic          busy,
    output logic          done,
    output logic [LW:0]   count
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    logic [N-1:0] pos_terms;
    logic [N-1:0] neg_terms;
    logic         z_pos;
    logic         z_neg;

    // Split the signed products onto a positive and a negative OR-rail.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_prod
            assign pos_terms[gi] = a[gi] & alpha[gi] & ~SIGN_alpha[gi];
            assign neg_terms[gi] = a[gi] & alpha[gi] &  SIGN_alpha[gi];
        end
    endgenerate

    assign z_pos = (|pos_terms) | (beta & ~SIGN_beta);
    assign z_neg = (|neg_terms) | (beta &  SIGN_beta);

    logic [CW-1:0] c_reg, c_next;
    logic          s_reg, s_next;
    logic          z_reg, z_next;

    always_comb begin
        c_next = c_reg;
        s_next = s_reg;
        z_next = 1'b0;
        if (z_pos ^ z_neg) begin
            if (z_neg == s_reg) begin
                // Matching polarity: drain pending cancellations before emitting.
                if (c_reg != '0) c_next = c_reg - 1'b1;
                else             z_next = 1'b1;
            end else begin
                if (&c_reg) begin
                    s_next = ~s_reg;
                    c_next = '0;
                end else begin
                    c_next = c_reg + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge CLK or posedge INIT) begin
        if (INIT) begin
            c_reg <= '0;
            s_reg <= 1'b0;
            z_reg <= 1'b0;
        end else begin
            c_reg <= c_next;
            s_reg <= s_next;
            z_reg <= z_next;
        end
    end

    assign z      = z_reg;
    assign SIGN_z = s_reg;
    assign zp     = ~s_reg;

    generate
        if (MODE == 0) begin : g_linear
            assign a_out      = z_reg;
            assign SIGN_a_out = s_reg;
        end else begin : g_relu
            assign a_out      = z_reg & ~s_reg;
            assign SIGN_a_out = 1'b0;
        end
    endgenerate

    state_t        state_reg, state_next;
    logic [LW-1:0] k_reg, k_next;
    logic [LW:0]   acc_reg, acc_next;
    logic [LW:0]   count_reg, count_next;
    logic [LW:0]   acc_sum;

    assign acc_sum = acc_reg + {{LW{1'b0}}, a_out};

    always_comb begin
        state_next = state_reg;
        k_next     = k_reg;
        acc_next   = acc_reg;
        count_next = count_reg;
        busy       = 1'b0;
        done       = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_RUN;
                    k_next     = '0;
                    acc_next   = '0;
                end
            end
            ST_RUN: begin
                busy     = 1'b1;
                acc_next = acc_sum;
                if (&k_reg) begin
                    state_next = ST_DONE;
                    count_next = acc_sum;
                end else begin
                    k_next = k_reg + 1'b1;
                end
            end
            ST_DONE: begin
                done = 1'b1;
                if (start) begin
                    state_next = ST_RUN;
                    k_next     = '0;
                    acc_next   = '0;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge INIT) begin
        if (INIT) begin
            state_reg <= ST_IDLE;
            k_reg     <= '0;
            acc_reg   <= '0;
            count_reg <= '0;
        end else begin
            state_reg <= state_next;
            k_reg     <= k_next;
            acc_reg   <= acc_next;
            count_reg <= count_next;
        end
    end

    assign count = count_reg;

endmodule

// File: tb/tb_nn_softconvnode_p.sv
// Directed bench for nn_softconvnode_p: a ReLU and a linear instance share stimulus.
module tb_nn_softconvnode_p;

    localparam int N  = 4;
    localparam int CW = 3;
    localparam int LW = 4;

    logic          CLK = 1'b0;
    logic          INIT = 1'b1;
    logic [N-1:0]  a = '0, alpha = '0, SIGN_alpha = '0;
    logic          beta = 1'b0, SIGN_beta = 1'b0, start = 1'b0;

    logic          z_r, sz_r, zp_r, ao_r, sao_r, busy_r, done_r;
    logic [LW:0]   count_r;
    logic          z_l, sz_l, zp_l, ao_l, sao_l, busy_l, done_l;
    logic [LW:0]   count_l;

    int check_count = 0;
    int pass_count  = 0;

    always #5 CLK = ~CLK;

    nn_softconvnode_p #(.N(N), .CW(CW), .LW(LW), .MODE(1)) dut_relu (
        .CLK(CLK), .INIT(INIT), .a(a), .alpha(alpha), .SIGN_alpha(SIGN_alpha),
        .beta(beta), .SIGN_beta(SIGN_beta), .start(start),
        .z(z_r), .SIGN_z(sz_r), .zp(zp_r), .a_out(ao_r), .SIGN_a_out(sao_r),
        .busy(busy_r), .done(done_r), .count(count_r)
    );

    nn_softconvnode_p #(.N(N), .CW(CW), .LW(LW), .MODE(0)) dut_lin (
        .CLK(CLK), .INIT(INIT), .a(a), .alpha(alpha), .SIGN_alpha(SIGN_alpha),
        .beta(beta), .SIGN_beta(SIGN_beta), .start(start),
        .z(z_l), .SIGN_z(sz_l), .zp(zp_l), .a_out(ao_l), .SIGN_a_out(sao_l),
        .busy(busy_l), .done(done_l), .count(count_l)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        check_count++;
        if (got === exp) begin
            pass_count++;
            $display("check %-20s got=%0d exp=%0d ok", tag, got, exp);
        end else begin
            $display("FAIL %-20s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        INIT = 1'b1;
        #2;
        tick();
        INIT = 1'b0;
    endtask

    // Pulse start, then count cycles from RUN entry to done (bounded).
    task automatic run_window(output int n);
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (!done_r && n < 60) begin
            tick();
            n++;
        end
    endtask

    initial begin
        int n;
        int ones;
        int dones;

        // Reset state, observed asynchronously with INIT held
        #3;
        chk("rst_z", z_r, 0);
        chk("rst_sign_z", sz_r, 0);
        chk("rst_zp", zp_r, 1);
        chk("rst_a_out", ao_r, 0);
        chk("rst_sign_a_out_lin", sao_l, 0);
        chk("rst_busy", busy_r, 0);
        chk("rst_done", done_r, 0);
        chk("rst_count", count_r, 0);

        // All positive
        a = 4'hF; alpha = 4'hF; SIGN_alpha = 4'h0; beta = 1'b0; SIGN_beta = 1'b0;
        do_reset();
        tick();
        chk("pos_z_c1", z_r, 1);
        chk("pos_sign_z_c1", sz_r, 0);
        chk("pos_a_out_c1", ao_r, 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("pos_busy_run", busy_r, 1);
        n = 0;
        while (!done_r && n < 60) begin
            tick();
            n++;
        end
        chk("pos_done_latency", n, 16);
        chk("pos_count", count_r, 16);
        chk("pos_busy_in_done", busy_r, 0);
        tick();
        chk("pos_done_one_cycle", done_r, 0);
        chk("pos_idle_busy", busy_r, 0);
        chk("pos_count_held", count_r, 16);

        // Window handshake: start held high
        start = 1'b1;
        n = 0;
        while (!done_r && n < 60) begin
            tick();
            n++;
        end
        chk("hs_first_done", n, 17);
        n = 0;
        tick();
        n++;
        while (!done_r && n < 60) begin
            tick();
            n++;
        end
        chk("hs_period", n, 17);
        n = 0;
        tick();
        n++;
        while (!done_r && n < 60) begin
            tick();
            n++;
        end
        chk("hs_period2", n, 17);
        chk("hs_count", count_r, 16);
        start = 1'b0;
        tick();
        chk("hs_back_idle", busy_r, 0);

        // Reset mid-window at k=5
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        chk("mid_busy_before", busy_r, 1);
        INIT = 1'b1;
        #1;
        chk("mid_busy", busy_r, 0);
        chk("mid_done", done_r, 0);
        chk("mid_count", count_r, 0);
        chk("mid_z", z_r, 0);
        tick();
        INIT = 1'b0;
        dones = 0;
        repeat (25) begin
            tick();
            if (done_r) dones++;
        end
        chk("mid_no_done", dones, 0);
        chk("mid_count_after", count_r, 0);

        // Polarity flip
        a = 4'hF; alpha = 4'hF; SIGN_alpha = 4'hF; beta = 1'b0; SIGN_beta = 1'b0;
        do_reset();
        ones = 0;
        for (int i = 1; i <= 7; i++) begin
            tick();
            if (z_r || sz_r) ones++;
        end
        chk("flip_c1_7_quiet", ones, 0);
        tick();
        chk("flip_c8_sign", sz_r, 1);
        chk("flip_c8_z", z_r, 0);
        chk("flip_c8_zp", zp_r, 0);
        tick();
        chk("flip_c9_z", z_r, 1);
        chk("flip_c9_sign_z", sz_r, 1);
        chk("flip_relu_a_out", ao_r, 0);
        chk("flip_relu_sign_a", sao_r, 0);
        chk("flip_lin_a_out", ao_l, 1);
        chk("flip_lin_sign_a", sao_l, 1);
        run_window(n);
        chk("flip_relu_count", count_r, 0);
        chk("flip_lin_count", count_l, 16);

        // Cancellation: positive product against negative bias
        a = 4'h1; alpha = 4'h1; SIGN_alpha = 4'h0; beta = 1'b1; SIGN_beta = 1'b1;
        do_reset();
        ones = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (!done_r && n < 60) begin
            if (z_r) ones++;
            tick();
            n++;
        end
        chk("cancel_z_ones", ones, 0);
        chk("cancel_count", count_r, 0);
        chk("cancel_lin_count", count_l, 0);
        beta = 1'b0;
        tick();
        chk("cancel_c_unchanged", z_r, 1);

        // Counter pre-charge: 3 opposite cycles then same-only cycles
        a = 4'hF; alpha = 4'hF; SIGN_alpha = 4'hF; beta = 1'b0; SIGN_beta = 1'b0;
        do_reset();
        repeat (3) tick();
        chk("pre_z_charge", z_r, 0);
        chk("pre_sign_kept", sz_r, 0);
        SIGN_alpha = 4'h0;
        tick();
        chk("pre_same1_z", z_r, 0);
        tick();
        chk("pre_same2_z", z_r, 0);
        tick();
        chk("pre_same3_z", z_r, 0);
        tick();
        chk("pre_same4_z", z_r, 1);
        tick();
        chk("pre_same5_z", z_r, 1);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule

// File: doc/nn_softconvnode_p.md
NN_SOFTCONVNODE_P -- requirements
Module: nn_softconvnode_p

Interface
REQ-001 SHALL have parameter N, default 4, meaning input window size (N >= 2).
REQ-002 SHALL have parameter CW, default 6, meaning width of the unsigned cancellation counter C.
REQ-003 SHALL have parameter LW, default 10, meaning log2 of the measurement window length in cycles.
REQ-004 SHALL have parameter MODE, default 1, meaning activation: 0 = linear (signed pass-through), 1 = ReLU.
REQ-005 SHALL have the following ports, in this order:
- CLK  in  1  clock; all state updates on the rising edge.
- INIT  in  1  reset, asynchronous and active-high.
- a  in  N  stochastic input bits.
- alpha  in  N  stochastic weight-magnitude bits.
- SIGN_alpha  in  N  weight signs; 1 = negative.
- beta  in  1  stochastic bias-magnitude bit.
- SIGN_beta  in  1  bias sign; 1 = negative.
- start  in  1  request to begin a measurement window.
- z  out  1  registered stochastic magnitude of the node sum.
- SIGN_z  out  1  registered polarity register S; 1 = negative.
- zp  out  1  ~SIGN_z.
- a_out  out  1  activation output bit.
- SIGN_a_out  out  1  activation sign.
- busy  out  1  high while in state RUN.
- done  out  1  one-cycle pulse at the end of a window.
- count  out  LW+1  number of a_out ones counted in the last completed window.

Function
REQ-006 SHALL form, combinationally, p[n] = a[n] & alpha[n] and pb = beta.
REQ-007 SHALL form, combinationally, z_pos = OR of all p[n] with SIGN_alpha[n]=0, OR'd with pb & ~SIGN_beta.
REQ-008 SHALL form, combinationally, z_neg = OR of all p[n] with SIGN_alpha[n]=1, OR'd with pb & SIGN_beta.
REQ-009 SHALL classify each cycle as follows:
- "same" = exactly one of z_pos/z_neg high and it matches S (z_pos when S=0, z_neg when S=1).
- "opposite" = exactly one high and it does not match S.
- "idle" = both high or both low.
REQ-010 SHALL, on an idle cycle, drive z<=0 and hold S and C.
REQ-011 SHALL, on a same cycle, do the following:
- If C>0: C<=C-1 and z<=0.
- If C=0: z<=1.
REQ-012 SHALL, on an opposite cycle, do the following:
- If C<2^CW-1: C<=C+1 and z<=0.
- If C=2^CW-1: S<=~S, C<=0 and z<=0 (polarity flip).
REQ-013 SHALL make z and SIGN_z registered outputs, so that input-to-z latency is exactly 1 cycle.
REQ-014 SHALL drive a_out, combinationally from the registered z and S, as follows:
- MODE 0: a_out = z and SIGN_a_out = S.
- MODE 1: a_out = z & ~S and SIGN_a_out = 0.
REQ-015 SHALL implement a window FSM with states IDLE, RUN and DONE, and a cycle counter k of LW bits.
REQ-016 SHALL handle state IDLE as follows:
- On start=1, go to RUN next cycle with k<=0 and acc<=0.
- count holds its previous value.
REQ-017 SHALL handle state RUN as follows:
- Each cycle, acc<=acc+a_out.
- When k=2^LW-1, go to DONE, with count<=acc+a_out.
- Otherwise k<=k+1.
- busy=1 throughout RUN.
REQ-018 SHALL handle state DONE as follows:
- done=1 for exactly one cycle.
- Go to IDLE, or go to RUN if start=1 in that cycle (k<=0, acc<=0).
REQ-019 SHALL ignore start in RUN (no restart, no error).
REQ-020 SHALL make count wide enough to hold 2^LW without wrap, and SHALL NOT let acc wrap.
REQ-021 SHALL leave the node datapath (C, S, z) free-running regardless of FSM state; windows only observe it.

Reset
REQ-022 SHALL, while INIT=1 and independent of CLK, drive:
- C=0, S=0, z=0.
- SIGN_z=0, zp=1.
- State IDLE with busy=0 and done=0.
- k=0, acc=0, count=0.
- Hence a_out=0 and SIGN_a_out=0.
REQ-023 SHALL, when INIT is asserted mid-window, abort that window with no done pulse; count reads 0 after release.
REQ-024 SHALL take the first state update after INIT deasserts on the next rising CLK edge.

Verification
REQ-025 SHALL pass scenario "all positive": N=4, LW=4, a=alpha=4'hF, SIGN_alpha=0, beta=0, start pulse.
- Response: z=1 and SIGN_z=0 from cycle 1 onward.
- Response: done is asserted 16 cycles after RUN entry, with count=16.
REQ-026 SHALL pass scenario "polarity flip": CW=3, all weights negative (SIGN_alpha=4'hF), a=alpha=4'hF, from reset.
- Response: C climbs 1..7 over cycles 1-7 with z=0.
- Response: S flips at cycle 8.
- Response: z=1 and SIGN_z=1 from cycle 9; MODE 1 gives a_out=0 and count=0; MODE 0 gives SIGN_a_out=1.
REQ-027 SHALL pass scenario "cancellation": one positive product and a negative bias, both 1 every cycle.
- Response: idle every cycle, z=0, C unchanged, count=0.
REQ-028 SHALL pass scenario "window handshake": start held high continuously.
- Response: back-to-back windows with done every 2^LW+1 cycles.
- Response: start pulses during RUN have no effect on k.
REQ-029 SHALL pass scenario "reset mid-window": INIT asserted at k=5.
- Response: immediately busy=0, done=0, count=0 and z=0; no done pulse follows.
REQ-030 SHALL pass scenario "counter pre-charge": CW=3, S=0, C=3 pre-loaded via 3 opposite cycles, then 5 same-only cycles.
- Response: z=0 for 3 cycles, then z=1 for 2 cycles, with C ending at 0.
